// File: rtl/main_memory_hs_pkg.sv
// Shared types and constants for the handshaked main memory.
package main_memory_hs_pkg;

    typedef enum logic [1:0] {MS_IDLE, MS_WAIT, MS_RESP} mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned WAIT_W = 4;

    // Access width in bytes implied by the low funct3 bits (11 is illegal, treated as a word).
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data accesses: legality check, store byte enables, load extension.
module mem_lane_align
    import main_memory_hs_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DMEM_BYTES = 1024
) (
    input  logic [2:0]      funct3,
    input  logic            write,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [31:0]     rword,
    output logic [3:0]      byte_en_c,
    output logic [31:0]     wr_data_c,
    output logic            fault_c,
    output logic [XLEN-1:0] ld_data_c
);

    logic [2:0]    size;
    logic [XLEN:0] last;
    logic          illegal;
    logic          misalign;
    logic          oob;

    // Classify the access and build the byte enables / extended load value.
    always_comb begin
        size      = access_size(funct3);
        last      = {1'b0, addr} + (XLEN+1)'(size);
        oob       = last > (XLEN+1)'(DMEM_BYTES);
        illegal   = write ? (funct3[2] || funct3[1:0] == 2'b11)
                          : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        misalign  = (funct3[1:0] == 2'b01 && addr[0]) ||
                    (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        fault_c   = illegal || misalign || oob;
        wr_data_c = wdata[31:0];

        byte_en_c = 4'b0000;
        if (write && !fault_c) begin
            case (size)
                3'd1:    byte_en_c = 4'b0001;
                3'd2:    byte_en_c = 4'b0011;
                default: byte_en_c = 4'b1111;
            endcase
        end

        ld_data_c = '0;
        if (!write && !fault_c) begin
            case (funct3)
                F3_B:    ld_data_c = {{(XLEN-8){rword[7]}}, rword[7:0]};
                F3_BU:   ld_data_c = {{(XLEN-8){1'b0}}, rword[7:0]};
                F3_H:    ld_data_c = {{(XLEN-16){rword[15]}}, rword[15:0]};
                F3_HU:   ld_data_c = {{(XLEN-16){1'b0}}, rword[15:0]};
                F3_W:    ld_data_c = XLEN'(rword);
                default: ld_data_c = '0;
            endcase
        end
    end

endmodule

// File: rtl/main_memory_hs.sv
// Split instruction/data main memory: combinational fetch port, handshaked data port with wait states.
module main_memory_hs
    import main_memory_hs_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned IMEM_BYTES  = 1024,
    parameter int unsigned DMEM_BYTES  = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [XLEN-1:0] InstrAddr,
    output logic [XLEN-1:0] InstrData,
    input  logic            ReqValid,
    output logic            ReqReady,
    input  logic            ReqWrite,
    input  logic [2:0]      ReqFunct3,
    input  logic [XLEN-1:0] ReqAddr,
    input  logic [XLEN-1:0] ReqWData,
    output logic            RespValid,
    input  logic            RespReady,
    output logic [XLEN-1:0] RespRData,
    output logic            RespFault
);

    localparam int unsigned IA_W = $clog2(IMEM_BYTES);
    localparam int unsigned DA_W = $clog2(DMEM_BYTES);

    logic [7:0] imem [IMEM_BYTES];
    logic [7:0] dmem [DMEM_BYTES];

    mem_state_t        state;
    logic [WAIT_W-1:0] cnt;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic [XLEN:0]     instr_last;
    logic [IA_W-1:0]   ia;
    logic [DA_W-1:0]   da;
    logic [31:0]       raw_word;
    logic [3:0]        byte_en_c;
    logic [31:0]       wr_data_c;
    logic              fault_c;
    logic [XLEN-1:0]   ld_data_c;
    logic              commit;

    // Fetch: aligned, fully in-range words only; anything else executes as a NOP.
    always_comb begin
        instr_last = {1'b0, InstrAddr} + (XLEN+1)'(3);
        ia         = InstrAddr[IA_W-1:0];
        InstrData  = XLEN'(NOP_INSTR);
        if (instr_last < (XLEN+1)'(IMEM_BYTES) && InstrAddr[1:0] == 2'b00)
            InstrData = XLEN'({imem[ia + IA_W'(3)], imem[ia + IA_W'(2)],
                               imem[ia + IA_W'(1)], imem[ia]});
    end

    // Raw little-endian bytes starting at the latched data address.
    always_comb begin
        da       = req_addr[DA_W-1:0];
        raw_word = '0;
        for (int i = 0; i < 4; i++)
            raw_word[8*i +: 8] = dmem[da + DA_W'(i)];
    end

    mem_lane_align #(
        .XLEN       (XLEN),
        .DMEM_BYTES (DMEM_BYTES)
    ) u_lane (
        .funct3    (req_funct3),
        .write     (req_write),
        .addr      (req_addr),
        .wdata     (req_wdata),
        .rword     (raw_word),
        .byte_en_c (byte_en_c),
        .wr_data_c (wr_data_c),
        .fault_c   (fault_c),
        .ld_data_c (ld_data_c)
    );

    // The access happens on the edge that raises RespValid.
    assign commit = (state == MS_RESP) && !RespValid;

    // Store commit; reset forces the FSM to IDLE so an aborted store never lands.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++)
            if (commit && byte_en_c[i])
                dmem[da + DA_W'(i)] <= wr_data_c[8*i +: 8];
    end

    // Request/response FSM with wait-state counter and registered handshake outputs.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= MS_IDLE;
            cnt        <= '0;
            ReqReady   <= 1'b0;
            RespValid  <= 1'b0;
            RespRData  <= '0;
            RespFault  <= 1'b0;
            req_write  <= 1'b0;
            req_funct3 <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
        end else begin
            case (state)
                MS_IDLE: begin
                    ReqReady <= 1'b1;
                    if (ReqValid && ReqReady) begin
                        ReqReady   <= 1'b0;
                        req_write  <= ReqWrite;
                        req_funct3 <= ReqFunct3;
                        req_addr   <= ReqAddr;
                        req_wdata  <= ReqWData;
                        cnt        <= WAIT_W'(WAIT_CYCLES);
                        state      <= (WAIT_CYCLES == 0) ? MS_RESP : MS_WAIT;
                    end
                end
                MS_WAIT: begin
                    cnt <= cnt - WAIT_W'(1);
                    if (cnt == WAIT_W'(1))
                        state <= MS_RESP;
                end
                MS_RESP: begin
                    if (!RespValid) begin
                        RespValid <= 1'b1;
                        RespFault <= fault_c;
                        RespRData <= ld_data_c;
                    end else if (RespReady) begin
                        RespValid <= 1'b0;
                        RespFault <= 1'b0;
                        RespRData <= '0;
                        ReqReady  <= 1'b1;
                        state     <= MS_IDLE;
                    end
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory_hs.sv
// Bench for main_memory_hs: byte-array reference model with per-cycle compare, plus literal checks.
module tb_main_memory_hs;
    import main_memory_hs_pkg::*;

    localparam int P    = 10;
    localparam int DMEM = 1024;
    localparam int IMEM = 1024;
    localparam int W    = 2;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] InstrAddr = '0;
    logic [31:0] InstrData, InstrData0;
    logic        ReqValid = 1'b0, ReqValid0 = 1'b0;
    logic        ReqReady, ReqReady0;
    logic        ReqWrite = 1'b0;
    logic [2:0]  ReqFunct3 = '0;
    logic [31:0] ReqAddr = '0, ReqWData = '0;
    logic        RespValid, RespValid0;
    logic        RespReady = 1'b1;
    logic [31:0] RespRData, RespRData0;
    logic        RespFault, RespFault0;

    int n_cmp = 0;
    int n_bad = 0;

    always #(P/2) CLK = ~CLK;

    main_memory_hs #(.XLEN(32), .IMEM_BYTES(IMEM), .DMEM_BYTES(DMEM), .WAIT_CYCLES(W), .INIT_FILE("")) dut (
        .CLK(CLK), .Reset(Reset), .InstrAddr(InstrAddr), .InstrData(InstrData),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqFunct3(ReqFunct3),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData), .RespValid(RespValid), .RespReady(RespReady),
        .RespRData(RespRData), .RespFault(RespFault));

    main_memory_hs #(.XLEN(32), .IMEM_BYTES(IMEM), .DMEM_BYTES(DMEM), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
        .CLK(CLK), .Reset(Reset), .InstrAddr(InstrAddr), .InstrData(InstrData0),
        .ReqValid(ReqValid0), .ReqReady(ReqReady0), .ReqWrite(ReqWrite), .ReqFunct3(ReqFunct3),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData), .RespValid(RespValid0), .RespReady(RespReady),
        .RespRData(RespRData0), .RespFault(RespFault0));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (main DUT only) ----------------
    logic [7:0]  mdl [DMEM];
    bit          pend = 0, applied = 0;
    time         acc_t = 0;
    logic [31:0] e_rdata;
    logic        e_fault;
    bit          e_store;
    int          e_addr, e_size;
    logic [31:0] e_wdata;

    task automatic model_issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int sz;
        bit legal, sgn;
        longint v;
        case (f3)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            default:        sz = 4;
        endcase
        legal = w ? (f3 inside {3'b000, 3'b001, 3'b010})
                  : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        sgn = (f3 == 3'b000 || f3 == 3'b001);
        e_fault = !legal || (longint'(a) + sz > DMEM) || ((longint'(a) % sz) != 0);
        e_rdata = '0;
        e_store = w && !e_fault;
        e_addr  = int'(a);
        e_size  = sz;
        e_wdata = wd;
        if (!w && !e_fault) begin
            v = 0;
            for (int i = 0; i < sz; i++) v = v | (longint'(mdl[e_addr + i]) << (8 * i));
            if (sgn && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
            e_rdata = v[31:0];
        end
    endtask

    // Per-cycle compare of the main DUT against the model.
    always @(negedge CLK) begin
        bit exp_rv;
        if (Reset) begin
            check("rst_req_ready", 32'(ReqReady), 32'd0);
            check("rst_resp_valid", 32'(RespValid), 32'd0);
            check("rst_resp_rdata", RespRData, 32'd0);
            check("rst_resp_fault", 32'(RespFault), 32'd0);
            pend = 0;
        end else begin
            exp_rv = pend && ($time > acc_t + (1 + W) * P);
            if (exp_rv && !applied) begin
                applied = 1;
                if (e_store)
                    for (int i = 0; i < e_size; i++) mdl[e_addr + i] = e_wdata[8*i +: 8];
            end
            check("cyc_resp_valid", 32'(RespValid), 32'(exp_rv));
            check("cyc_resp_rdata", RespRData, exp_rv ? e_rdata : 32'd0);
            check("cyc_resp_fault", 32'(RespFault), exp_rv ? 32'(e_fault) : 32'd0);
            if (pend) check("cyc_req_ready_busy", 32'(ReqReady), 32'd0);
            if (exp_rv && RespReady) pend = 0;
        end
    end

    // ---------------- drivers (called at posedge+1) ----------------
    function automatic logic rdy(input int sel);
        return (sel == 0) ? ReqReady0 : ReqReady;
    endfunction

    task automatic issue_req(input int sel, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        bit ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (rdy(sel)) begin ok = 1; break; end
            @(posedge CLK); #1;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL req_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        ReqWrite = w; ReqFunct3 = f3; ReqAddr = a; ReqWData = wd;
        if (sel == 0) ReqValid0 = 1'b1; else ReqValid = 1'b1;
        @(posedge CLK);
        if (sel != 0) begin
            model_issue(w, f3, a, wd);
            acc_t = $time; applied = 0; pend = 1;
        end
        #1;
        ReqValid = 1'b0; ReqValid0 = 1'b0;
        // Junk after accept: must have no effect on the latched request.
        ReqWrite = ~w; ReqFunct3 = 3'b111; ReqAddr = 32'h0000_03FC; ReqWData = 32'hFFFF_FFFF;
    endtask

    task automatic wait_resp(input int sel, output int lat, output logic [31:0] rd, output logic f);
        bit seen = 0;
        lat = 0; rd = '0; f = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            lat++;
            if ((sel == 0) ? RespValid0 : RespValid) begin
                rd = (sel == 0) ? RespRData0 : RespRData;
                f  = (sel == 0) ? RespFault0 : RespFault;
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_timeout: got 0 expected 1 at %0t", $time);
            pend = 0;
        end else if (RespReady) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic do_req(input string name, input int sel, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_f);
        int lat;
        logic [31:0] rd;
        logic f;
        issue_req(sel, w, f3, a, wd);
        wait_resp(sel, lat, rd, f);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_fault"}, 32'(f), 32'(exp_f));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        logic [31:0] rd;
        logic f;

        #1 Reset = 1'b1;
        dut.imem[0] = 8'h93; dut.imem[1] = 8'h00; dut.imem[2] = 8'h50; dut.imem[3] = 8'h00;
        dut.imem[1020] = 8'h0D; dut.imem[1021] = 8'hF0; dut.imem[1022] = 8'hFE; dut.imem[1023] = 8'hCA;
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b0;

        // Fetch port
        InstrAddr = 32'd0;           #1 check("fetch_0", InstrData, 32'h0050_0093);
        InstrAddr = 32'd1020;        #1 check("fetch_last", InstrData, 32'hCAFE_F00D);
        InstrAddr = 32'd1024;        #1 check("fetch_oob", InstrData, NOP_INSTR);
        check("fetch_oob_w0", InstrData0, NOP_INSTR);
        InstrAddr = 32'd2;           #1 check("fetch_misalign", InstrData, NOP_INSTR);
        InstrAddr = 32'hFFFF_FFFC;   #1 check("fetch_wrap", InstrData, NOP_INSTR);
        @(posedge CLK); #1;

        // Stores, latency
        do_req("sw0", 2, 1'b1, F3_W, 32'd0, 32'h5566_7788, 32'd0, 1'b0);
        do_req("sw4", 2, 1'b1, F3_W, 32'd4, 32'h0123_4567, 32'd0, 1'b0);
        issue_req(2, 1'b1, F3_W, 32'd8, 32'hDEAD_BEEF);
        wait_resp(2, lat, rd, f);
        check("sw8_latency", 32'(lat), 32'd3);
        check("sw8_fault", 32'(f), 32'd0);
        do_req("lw8", 2, 1'b0, F3_W, 32'd8, 32'd0, 32'hDEAD_BEEF, 1'b0);

        // Load extension
        do_req("lb8",   2, 1'b0, F3_B,  32'd8,  32'd0, 32'hFFFF_FFEF, 1'b0);
        do_req("lbu8",  2, 1'b0, F3_BU, 32'd8,  32'd0, 32'h0000_00EF, 1'b0);
        do_req("lh10",  2, 1'b0, F3_H,  32'd10, 32'd0, 32'hFFFF_DEAD, 1'b0);
        do_req("lhu10", 2, 1'b0, F3_HU, 32'd10, 32'd0, 32'h0000_DEAD, 1'b0);

        // Faults and boundaries
        do_req("sw6_mis",   2, 1'b1, F3_W,   32'd6,        32'hAAAA_AAAA, 32'd0, 1'b1);
        do_req("lw4_keep",  2, 1'b0, F3_W,   32'd4,        32'd0, 32'h0123_4567, 1'b0);
        do_req("lw8_keep",  2, 1'b0, F3_W,   32'd8,        32'd0, 32'hDEAD_BEEF, 1'b0);
        do_req("lw_oob",    2, 1'b0, F3_W,   32'd1022,     32'd0, 32'd0, 1'b1);
        do_req("lw_wrap",   2, 1'b0, F3_W,   32'hFFFF_FFFC, 32'd0, 32'd0, 1'b1);
        do_req("ld_f3_011", 2, 1'b0, 3'b011, 32'd8,        32'd0, 32'd0, 1'b1);
        do_req("st_f3_100", 2, 1'b1, 3'b100, 32'd8,        32'h1234_5678, 32'd0, 1'b1);
        do_req("sw1020",    2, 1'b1, F3_W,   32'd1020,     32'hA5A5_5A5A, 32'd0, 1'b0);
        do_req("lw1020",    2, 1'b0, F3_W,   32'd1020,     32'd0, 32'hA5A5_5A5A, 1'b0);
        do_req("lb1023",    2, 1'b0, F3_B,   32'd1023,     32'd0, 32'hFFFF_FFA5, 1'b0);
        do_req("lh1022",    2, 1'b0, F3_H,   32'd1022,     32'd0, 32'hFFFF_A5A5, 1'b0);
        do_req("lhu_mis",   2, 1'b0, F3_HU,  32'd1023,     32'd0, 32'd0, 1'b1);
        do_req("lbu_oob",   2, 1'b0, F3_BU,  32'd1024,     32'd0, 32'd0, 1'b1);
        do_req("sb9",       2, 1'b1, F3_B,   32'd9,        32'hFFFF_FF11, 32'd0, 1'b0);
        do_req("lw8_sb",    2, 1'b0, F3_W,   32'd8,        32'd0, 32'hDEAD_11EF, 1'b0);
        do_req("sh10",      2, 1'b1, F3_H,   32'd10,       32'hFFFF_7788, 32'd0, 1'b0);
        do_req("lw8_sh",    2, 1'b0, F3_W,   32'd8,        32'd0, 32'h7788_11EF, 1'b0);

        // Backpressure: response held, new requests ignored
        RespReady = 1'b0;
        issue_req(2, 1'b0, F3_W, 32'd8, 32'd0);
        wait_resp(2, lat, rd, f);
        check("hold_first_rdata", rd, 32'h7788_11EF);
        for (int k = 0; k < 5; k++) begin
            ReqValid = 1'b1; ReqWrite = 1'b1; ReqFunct3 = F3_W; ReqAddr = 32'd0; ReqWData = 32'd0;
            @(posedge CLK); #1;
            check("hold_valid", 32'(RespValid), 32'd1);
            check("hold_rdata", RespRData, 32'h7788_11EF);
            check("hold_req_ready", 32'(ReqReady), 32'd0);
        end
        ReqValid = 1'b0;
        RespReady = 1'b1;
        @(posedge CLK); #1;
        check("release_valid", 32'(RespValid), 32'd0);
        check("release_req_ready", 32'(ReqReady), 32'd1);

        // Reset during WAIT drops the store
        issue_req(2, 1'b1, F3_W, 32'd0, 32'h1122_3344);
        @(posedge CLK); #1;
        Reset = 1'b1;
        #1;
        check("abort_req_ready", 32'(ReqReady), 32'd0);
        check("abort_resp_valid", 32'(RespValid), 32'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        do_req("lw0_old", 2, 1'b0, F3_W, 32'd0, 32'd0, 32'h5566_7788, 1'b0);

        // Zero wait states
        issue_req(0, 1'b1, F3_W, 32'd16, 32'h0BAD_F00D);
        wait_resp(0, lat, rd, f);
        check("w0_sw_latency", 32'(lat), 32'd1);
        check("w0_sw_fault", 32'(f), 32'd0);
        issue_req(0, 1'b0, F3_W, 32'd16, 32'd0);
        wait_resp(0, lat, rd, f);
        check("w0_lw_latency", 32'(lat), 32'd1);
        check("w0_lw_rdata", rd, 32'h0BAD_F00D);
        issue_req(0, 1'b1, F3_W, 32'd16, 32'hFFFF_FFFF);
        Reset = 1'b1;
        #1;
        check("w0_abort_valid", 32'(RespValid0), 32'd0);
        check("w0_abort_ready", 32'(ReqReady0), 32'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        do_req("w0_lw_old", 0, 1'b0, F3_W, 32'd16, 32'd0, 32'h0BAD_F00D, 1'b0);

        repeat (2) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #(P * 20000);
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
